// File: rtl/fetch_queue.sv
// Instruction fetch queue: keeps each fetch group up to its first jump, buffers
// the instructions in a circular FIFO and offers up to two per cycle to decode.
module fetch_queue #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 64,
  parameter int MAX_IN  = 10
) (
  input  logic                        i_fire,
  input  logic                        rst,
  input  logic                        i_enqValid,
  input  logic [MAX_IN*ENTRY_W-1:0]   i_alignedInstructionTableBus_640,
  input  logic [3:0]                  i_alignedInstructionNumber_4,
  input  logic                        i_cutValid,
  input  logic [7:0]                  i_cutPosition_8,
  input  logic                        i_flush,
  input  logic [1:0]                  i_deqCount_2,
  output logic                        o_enqReady,
  output logic [1:0]                  o_deqValid_2,
  output logic [ENTRY_W-1:0]          o_deqEntry0_64,
  output logic [ENTRY_W-1:0]          o_deqEntry1_64,
  output logic [$clog2(DEPTH):0]      o_count_5
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] entries [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic [CNT_W-1:0]   numLen;
  logic [CNT_W-1:0]   groupLen;
  logic [CNT_W-1:0]   enqLen;
  logic [1:0]         deqEff;
  logic               enqAccept;
  logic               wrEn   [DEPTH];
  logic [ENTRY_W-1:0] wrData [DEPTH];
  logic [PTR_W-1:0]   wrIdx;
  logic               unusedCutHi;

  assign unusedCutHi = ^i_cutPosition_8[7:5];

  // Dequeue is not credited here, so an accepted group can never overflow.
  assign o_enqReady = (count <= CNT_W'(DEPTH - MAX_IN));
  assign enqAccept  = i_enqValid & o_enqReady & ~i_flush;

  always_comb begin
    numLen = CNT_W'(i_alignedInstructionNumber_4);
    if (numLen > CNT_W'(MAX_IN)) begin
      numLen = CNT_W'(MAX_IN);
    end
    groupLen = numLen;
    if (i_cutValid && (int'(i_cutPosition_8[4:0]) < int'(numLen))) begin
      groupLen = CNT_W'(i_cutPosition_8[4:0]) + CNT_W'(1);
    end
    enqLen = enqAccept ? groupLen : '0;
  end

  always_comb begin
    deqEff = i_deqCount_2;
    if (CNT_W'(i_deqCount_2) > count) begin
      deqEff = count[1:0];
    end
  end

  // Scatter group slot k to entry (tail + k) mod DEPTH.
  always_comb begin
    wrIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wrEn[i]   = 1'b0;
      wrData[i] = '0;
    end
    for (int k = 0; k < MAX_IN; k++) begin
      wrIdx = tail + PTR_W'(k);
      if (CNT_W'(k) < enqLen) begin
        wrEn[wrIdx]   = 1'b1;
        wrData[wrIdx] = i_alignedInstructionTableBus_640[k*ENTRY_W +: ENTRY_W];
      end
    end
  end

  always_ff @(posedge i_fire) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deqEff);
      tail  <= tail + PTR_W'(enqLen);
      count <= count + enqLen - CNT_W'(deqEff);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : gen_entry
    always_ff @(posedge i_fire) begin
      if (rst) begin
        entries[g] <= '0;
      end else if (wrEn[g]) begin
        entries[g] <= wrData[g];
      end
    end
  end

  assign o_deqValid_2   = {count >= CNT_W'(2), count != '0};
  assign o_deqEntry0_64 = entries[head];
  assign o_deqEntry1_64 = entries[head + PTR_W'(1)];
  assign o_count_5      = count;

endmodule
